// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle shifts/add/sub/logic/compares plus
// iterative (one bit per cycle) signed/unsigned multiply and divide.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             OF,
  output logic             CF,
  output logic             equal,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] SEL_SHL  = 4'd0;
  localparam logic [3:0] SEL_ASR  = 4'd1;
  localparam logic [3:0] SEL_LSR  = 4'd2;
  localparam logic [3:0] SEL_MULU = 4'd3;
  localparam logic [3:0] SEL_DIVU = 4'd4;
  localparam logic [3:0] SEL_ADD  = 4'd5;
  localparam logic [3:0] SEL_SUB  = 4'd6;
  localparam logic [3:0] SEL_AND  = 4'd7;
  localparam logic [3:0] SEL_OR   = 4'd8;
  localparam logic [3:0] SEL_XOR  = 4'd9;
  localparam logic [3:0] SEL_NOR  = 4'd10;
  localparam logic [3:0] SEL_SLT  = 4'd11;
  localparam logic [3:0] SEL_SLTU = 4'd12;
  localparam logic [3:0] SEL_MULS = 4'd13;
  localparam logic [3:0] SEL_DIVS = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result2_q, result2_d;
  logic               of_q, of_d;
  logic               cf_q, cf_d;
  logic               equal_q, equal_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;

  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_of_s;
  logic               alu_cf_s;
  logic [WIDTH:0]     sum_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               sel_signed_s;

  logic [WIDTH-1:0]   mul_add_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_rs_s;
  logic [WIDTH:0]     div_diff_s;
  logic [WIDTH-1:0]   step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;
  logic [2*WIDTH-1:0] fin_prod_s;
  logic [WIDTH-1:0]   fin_quo_s;
  logic [WIDTH-1:0]   fin_rem_s;

  // Magnitude of a two's-complement operand when the op is signed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
  endfunction

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign result2     = result2_q;
  assign OF          = of_q;
  assign CF          = cf_q;
  assign equal       = equal_q;
  assign div_by_zero = dbz_q;

  // Single-cycle datapath evaluated on the live operands at accept time.
  always_comb begin
    alu_res_s    = ZERO;
    alu_of_s     = 1'b0;
    alu_cf_s     = 1'b0;
    sum_s        = {1'b0, ZERO};
    shamt_s      = y[SHAMT_W-1:0];
    sel_signed_s = (sel == SEL_MULS) || (sel == SEL_DIVS);
    case (sel)
      SEL_SHL:  alu_res_s = x << shamt_s;
      SEL_ASR:  alu_res_s = $signed(x) >>> shamt_s;
      SEL_LSR:  alu_res_s = x >> shamt_s;
      SEL_ADD: begin
        sum_s     = {1'b0, x} + {1'b0, y};
        alu_res_s = sum_s[WIDTH-1:0];
        alu_cf_s  = sum_s[WIDTH];
        alu_of_s  = (x[WIDTH-1] ^ y[WIDTH-1] ^ sum_s[WIDTH-1]) ^ sum_s[WIDTH];
      end
      SEL_SUB: begin
        sum_s     = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        alu_res_s = sum_s[WIDTH-1:0];
        alu_cf_s  = sum_s[WIDTH];
        alu_of_s  = (x[WIDTH-1] ^ ~y[WIDTH-1] ^ sum_s[WIDTH-1]) ^ sum_s[WIDTH];
      end
      SEL_AND:  alu_res_s = x & y;
      SEL_OR:   alu_res_s = x | y;
      SEL_XOR:  alu_res_s = x ^ y;
      SEL_NOR:  alu_res_s = ~(x | y);
      SEL_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      SEL_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (x < y)};
      default:  alu_res_s = ZERO;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus sign fix-up.
  always_comb begin
    mul_add_s  = acc_lo_q[0] ? opnd_q : ZERO;
    mul_sum_s  = {1'b0, acc_hi_q} + {1'b0, mul_add_s};
    div_rs_s   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff_s = div_rs_s - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_diff_s[WIDTH]) begin
        step_hi_s = div_diff_s[WIDTH-1:0];
        step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = div_rs_s[WIDTH-1:0];
        step_lo_s = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
    end
    fin_prod_s = neg_lo_q ? -{step_hi_s, step_lo_s} : {step_hi_s, step_lo_s};
    fin_quo_s  = neg_lo_q ? -step_lo_s : step_lo_s;
    fin_rem_s  = neg_hi_q ? -step_hi_s : step_hi_s;
  end

  // Next-state and output-register update logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result2_d   = result2_q;
    of_d        = of_q;
    cf_d        = cf_q;
    equal_d     = equal_q;
    dbz_d       = dbz_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          equal_d = (x == y);
          of_d    = 1'b0;
          cf_d    = 1'b0;
          dbz_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          case (sel)
            SEL_MULU, SEL_MULS: begin
              acc_hi_d = ZERO;
              acc_lo_d = mag(y, sel_signed_s);
              opnd_d   = mag(x, sel_signed_s);
              is_div_d = 1'b0;
              neg_lo_d = sel_signed_s && (x[WIDTH-1] ^ y[WIDTH-1]);
              neg_hi_d = 1'b0;
              state_d  = CALC;
            end
            SEL_DIVU, SEL_DIVS: begin
              if (y == ZERO) begin
                result_d    = ONES;
                result2_d   = x;
                dbz_d       = 1'b1;
                out_valid_d = 1'b1;
                state_d     = DONE;
              end else if (sel_signed_s && (x == MINV) && (y == ONES)) begin
                result_d    = x;
                result2_d   = ZERO;
                of_d        = 1'b1;
                out_valid_d = 1'b1;
                state_d     = DONE;
              end else begin
                acc_hi_d = ZERO;
                acc_lo_d = mag(x, sel_signed_s);
                opnd_d   = mag(y, sel_signed_s);
                is_div_d = 1'b1;
                neg_lo_d = sel_signed_s && (x[WIDTH-1] ^ y[WIDTH-1]);
                neg_hi_d = sel_signed_s && x[WIDTH-1];
                state_d  = CALC;
              end
            end
            default: begin
              result_d    = alu_res_s;
              result2_d   = ZERO;
              of_d        = alu_of_s;
              cf_d        = alu_cf_s;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
          if (is_div_q) begin
            result_d  = fin_quo_s;
            result2_d = fin_rem_s;
          end else begin
            result_d  = fin_prod_s[WIDTH-1:0];
            result2_d = fin_prod_s[2*WIDTH-1:WIDTH];
          end
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= ZERO;
      result2_q   <= ZERO;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      equal_q     <= 1'b0;
      dbz_q       <= 1'b0;
      acc_hi_q    <= ZERO;
      acc_lo_q    <= ZERO;
      opnd_q      <= ZERO;
      cnt_q       <= {CNT_W{1'b0}};
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result2_q   <= result2_d;
      of_q        <= of_d;
      cf_q        <= cf_d;
      equal_q     <= equal_d;
      dbz_q       <= dbz_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a vector table for every op group plus
// hand-written sequences for busy handling, output hold and mid-op reset.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [3:0]   sel = 4'd0;
  logic         in_ready, out_valid, OF, CF, equal, div_by_zero, busy;
  logic [W-1:0] result, result2;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result2(result2), .OF(OF), .CF(CF), .equal(equal),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
    logic [W-1:0] res2;
    logic [3:0]   flags;   // {OF, CF, equal, div_by_zero}
    int           cyc;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after out_valid is seen.
  task automatic issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc);
    sel = s; x = a; y = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom; y = $urandom; sel = 4'($urandom_range(15, 0));
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int bad;

    vecs[0]  = '{4'd5,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b1000, 1};
    vecs[1]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b0100, 1};
    vecs[2]  = '{4'd6,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 4'b0110, 1};
    vecs[3]  = '{4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b1100, 1};
    vecs[4]  = '{4'd0,  32'h00000001, 32'h00000024, 32'h00000010, 32'h0, 4'b0000, 1};
    vecs[5]  = '{4'd1,  32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 4'b0000, 1};
    vecs[6]  = '{4'd2,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 4'b0000, 1};
    vecs[7]  = '{4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 4'b0000, 1};
    vecs[8]  = '{4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 4'b0000, 1};
    vecs[9]  = '{4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 4'b0000, 1};
    vecs[10] = '{4'd10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 4'b0000, 1};
    vecs[11] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 4'b0000, 1};
    vecs[12] = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b0000, 1};
    vecs[13] = '{4'd15, 32'h00000003, 32'h00000003, 32'h00000000, 32'h0, 4'b0010, 1};
    vecs[14] = '{4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b0010, 33};
    vecs[15] = '{4'd4,  32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 4'b0000, 33};
    vecs[16] = '{4'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0000, 33};
    vecs[17] = '{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 4'b1000, 1};
    vecs[18] = '{4'd4,  32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, 4'b0001, 1};
    vecs[19] = '{4'd7,  32'h00000064, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000, 1};
    vecs[20] = '{4'd13, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b0000, 33};
    vecs[21] = '{4'd14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 4'b0000, 33};
    vecs[22] = '{4'd4,  32'h80000000, 32'h00000010, 32'h08000000, 32'h00000000, 4'b0000, 33};
    vecs[23] = '{4'd3,  32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 4'b0000, 33};

    // Reset state, during and after reset.
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_outs", {out_valid, OF, CF, equal, div_by_zero}, 0);
    check("rst_result", {result, result2}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {in_ready, busy, out_valid}, 3'b100);

    // Table-driven vectors, each with a handoff back to IDLE.
    for (int i = 0; i < 24; i++) begin
      issue(vecs[i].sel, vecs[i].x, vecs[i].y, cyc);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_result2", i), result2, vecs[i].res2);
      check($sformatf("v%0d_flags", i), {OF, CF, equal, div_by_zero}, vecs[i].flags);
      @(posedge clk); #1;
      check($sformatf("v%0d_handoff", i), {in_ready, out_valid, busy}, 3'b100);
    end

    // Busy for the whole multiply; in_valid pulses during CALC are dropped.
    sel = 4'd3; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1; bad = 0;
    while (!out_valid && cyc < 200) begin
      if (!busy || in_ready) bad++;
      in_valid = ((cyc % 3) == 0) && (cyc < 25);
      sel = 4'd5; x = 32'h1; y = 32'h2;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("busy_mul_cycles", cyc, 33);
    check("busy_mul_busy", bad, 0);
    check("busy_mul_result", {result2, result}, 64'hFFFFFFFE_00000001);
    @(posedge clk); #1;
    bad = 0;
    repeat (3) begin
      if (out_valid || busy) bad++;
      @(posedge clk); #1;
    end
    check("busy_no_queued_op", bad, 0);

    // Held output while the consumer stalls.
    out_ready = 1'b0;
    issue(4'd13, 32'hFFFFFFFE, 32'h00000003, cyc);
    check("hold_cycles", cyc, 33);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== 32'hFFFFFFFA || result2 !== 32'hFFFFFFFF) bad++;
    end
    check("hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {out_valid, in_ready}, 2'b01);
    check("hold_keeps_result", result, 32'hFFFFFFFA);

    // Reset in the 10th CALC cycle of a divide.
    sel = 4'd4; x = 32'd100; y = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_in_calc", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {out_valid, OF, CF, equal, div_by_zero}, 0);
    check("abort_result", {result, result2}, 0);
    check("abort_ready", {in_ready, busy}, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    check("abort_no_result", bad, 0);
    issue(4'd4, 32'd100, 32'd7, cyc);
    check("fresh_div_cycles", cyc, 33);
    check("fresh_div_result", {result, result2}, {32'd14, 32'd2});
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
